// File: rtl/mc_cu.sv
// Multicycle control unit for a MIPS-subset datapath: five-phase FSM with
// optional memory handshake, trap state and a retired-instruction counter.
//
// state | meaning
// IF    | fetch instruction, PC <= PC + 4
// ID    | decode, branch target into ALU register, jumps complete here
// EXE   | ALU operation; branches resolve here
// MEM   | data memory access via ALU result address
// WB    | register-file write
// TRAP  | illegal instruction seen; held until reset
module mc_cu #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_rdy,
    output logic             wpc,
    output logic             wir,
    output logic             wmem,
    output logic             wreg,
    output logic             iord,
    output logic             regrt,
    output logic             m2reg,
    output logic             shift,
    output logic             sext,
    output logic             jal,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [3:0]       aluc,
    output logic [1:0]       pcsource,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    state_t cur, nxt;

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic is_shift, is_rr, is_imm, is_legal, mem_done;
    logic [3:0] exe_aluc;

    assign r_type = (op == 6'b000000);
    assign i_add  = r_type && (func == 6'b100000);
    assign i_sub  = r_type && (func == 6'b100010);
    assign i_and  = r_type && (func == 6'b100100);
    assign i_or   = r_type && (func == 6'b100101);
    assign i_xor  = r_type && (func == 6'b100110);
    assign i_sll  = r_type && (func == 6'b000000);
    assign i_srl  = r_type && (func == 6'b000010);
    assign i_sra  = r_type && (func == 6'b000011);
    assign i_jr   = r_type && (func == 6'b001000);
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_lui  = (op == 6'b001111);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    assign is_shift = i_sll | i_srl | i_sra;
    assign is_rr    = i_add | i_sub | i_and | i_or | i_xor | is_shift;
    assign is_imm   = i_addi | i_andi | i_ori | i_xori | i_lui;
    assign is_legal = is_rr | i_jr | is_imm | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;
    assign mem_done = (MEM_HANDSHAKE == 0) || mem_rdy;

    always_comb begin
        exe_aluc = 4'b0000;
        if (i_sub || i_beq || i_bne)  exe_aluc = 4'b0100;
        else if (i_and || i_andi)     exe_aluc = 4'b0001;
        else if (i_or || i_ori)       exe_aluc = 4'b0101;
        else if (i_xor || i_xori)     exe_aluc = 4'b0010;
        else if (i_lui)               exe_aluc = 4'b0110;
        else if (i_sll)               exe_aluc = 4'b0011;
        else if (i_srl)               exe_aluc = 4'b0111;
        else if (i_sra)               exe_aluc = 4'b1111;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cur <= S_IF;
        else         cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        jal      = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluc     = 4'b0000;
        pcsource = 2'b00;
        illegal  = 1'b0;
        case (cur)
            S_IF: begin
                alusrcb = 2'b01;
                if (mem_done) begin
                    wir = 1'b1;
                    wpc = 1'b1;
                    nxt = S_ID;
                end
            end
            S_ID: begin
                alusrcb = 2'b11;
                sext    = 1'b1;
                if (i_j || i_jal) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    wreg     = i_jal;
                    jal      = i_jal;
                    nxt      = S_IF;
                end else if (i_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                    nxt      = S_IF;
                end else if (!is_legal) begin
                    nxt = S_TRAP;
                end else begin
                    nxt = S_EXE;
                end
            end
            S_EXE: begin
                shift   = is_shift;
                alusrca = ~is_shift;
                alusrcb = (is_rr || i_beq || i_bne) ? 2'b00 : 2'b10;
                sext    = i_addi | i_lw | i_sw | i_beq | i_bne;
                aluc    = exe_aluc;
                if (i_beq || i_bne) begin
                    pcsource = 2'b01;
                    wpc      = (i_beq & z) | (i_bne & ~z);
                    nxt      = S_IF;
                end else if (i_lw || i_sw) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                // The store strobe only fires in the cycle memory accepts it
                if (mem_done) begin
                    wmem = i_sw;
                    nxt  = i_sw ? S_IF : S_WB;
                end
            end
            S_WB: begin
                wreg  = 1'b1;
                m2reg = i_lw;
                regrt = is_imm | i_lw;
                nxt   = S_IF;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                         instret <= '0;
        else if (nxt == S_IF && cur != S_IF) instret <= instret + CNT_W'(1);
    end

    assign state = cur;

endmodule

// File: doc/mc_cu.md
MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1; 1 = IF/MEM states wait on mem_rdy, 0 = memory assumed single-cycle, mem_rdy ignored.
REQ-002 Parameter CNT_W, default 32; width of retired-instruction counter.
REQ-003 clock  in  1  single clock, all state updates on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 op  in  6  opcode field from instruction register.
REQ-006 func  in  6  function field from instruction register.
REQ-007 z  in  1  ALU zero flag.
REQ-008 mem_rdy  in  1  memory access complete this cycle.
REQ-009 wpc, wir, wmem, wreg  out  1 each  PC / IR / data-memory / register-file write enables.
REQ-010 iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 regrt, m2reg, shift, sext, jal  out  1 each  rt destination, memory-to-reg, shamt as operand A, sign-extend, write $31 with PC.
REQ-012 alusrca  out  1  0 = PC, 1 = register A; alusrcb  out  2  00 = reg B, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2.
REQ-013 aluc  out  4; pcsource  out  2  00 = ALU, 01 = branch-target register, 10 = rs, 11 = jump address.
REQ-014 state  out  3; illegal  out  1  trap flag; instret  out  CNT_W  retired-instruction count.

Function
REQ-015 FSM states: IF=0, ID=1, EXE=2, MEM=3, WB=4, TRAP=7; state register is the only control storage besides instret.
REQ-016 Decoded instructions: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal; any other op/func is illegal.
REQ-017 ALU codes: add x000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111.
REQ-018 IF: iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00; if MEM_HANDSHAKE=0 or mem_rdy=1 then wir=wpc=1 and next state ID, otherwise wir=wpc=0 and remain in IF.
REQ-019 ID: alusrca=0, alusrcb=11, sext=1, aluc=add (branch target computed); j: wpc=1, pcsource=11 -> IF; jal: additionally wreg=1, jal=1; jr: wpc=1, pcsource=10 -> IF; illegal -> TRAP; all others -> EXE.
REQ-020 EXE: alusrca=1, or shift=1 for sll/srl/sra; alusrcb=00 for R-type/beq/bne, 10 for I-type/lw/sw; sext per REQ-023.
REQ-021 EXE, beq/bne: aluc=sub, pcsource=01, wpc=(beq&z)|(bne&~z), next IF; lw/sw -> MEM; others -> WB.
REQ-022 MEM: iord=1; sw: wmem=1 -> IF; lw -> WB; with MEM_HANDSHAKE=1 and mem_rdy=0: wmem=0, remain in MEM (wmem asserted only in the completing cycle).
REQ-023 sext=1 for addi, lw, sw, beq, bne; 0 for andi, ori, xori, lui.
REQ-024 WB: wreg=1; m2reg=1 only for lw; regrt=1 for addi, andi, ori, xori, lw, lui; next IF.
REQ-025 All outputs not listed for a state are 0; control outputs are combinational from state, op, func, z, mem_rdy.
REQ-026 TRAP: illegal=1, all write enables 0, remain in TRAP until resetn asserted.
REQ-027 instret increments by 1 on every clock edge where the next state is IF and the current state is not IF; wraps from 2^CNT_W-1 to 0.
REQ-028 Entry to TRAP does not increment instret.

Reset
REQ-029 resetn=0 forces state=IF, instret=0, illegal=0 immediately (asynchronous), regardless of clock, including mid-instruction or in TRAP.
REQ-030 First rising edge after resetn deasserts performs a normal IF cycle.

Verification
REQ-031 add $3,$1,$2 with mem_rdy=1 -> states IF,ID,EXE,WB,IF; wreg=1 only in WB with regrt=0; instret 0->1.
REQ-032 lw with mem_rdy low 3 cycles in MEM -> MEM held 4 cycles, iord=1 throughout, then WB with m2reg=1, regrt=1; total 8 cycles.
REQ-033 beq with z=1 then z=0 -> wpc=1/pcsource=01 in EXE for first, wpc=0 for second; both return to IF after 3 states.
REQ-034 jal -> IF,ID,IF; ID shows wpc=1, wreg=1, jal=1, pcsource=11; instret +1.
REQ-035 op=6'b111111 -> TRAP after ID, illegal=1, instret unchanged; resetn pulse mid-cycle -> state=IF, illegal=0 before next edge.
REQ-036 CNT_W=4, 16 retired instructions from 0 -> instret wraps to 0.
